// File: rtl/id_ex_ula.sv
// ID/EX pipeline register feeding the 32-bit ULA: OP decode, immediate extension, stall/flush.
// Define ID_EX_ULA_FWD_EN to enable EX/MEM and MEM/WB operand forwarding.
module id_ex_ula #(
    parameter int unsigned W  = 32,
    parameter int unsigned RW = 5
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          stall,
    input  logic          flush,
    input  logic          id_valid,
    input  logic [W-1:0]  id_rs_val,
    input  logic [W-1:0]  id_rt_val,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic [15:0]   id_imm,
    input  logic [1:0]    id_alu_op,
    input  logic [5:0]    id_funct,
    input  logic [1:0]    id_imm_op,
    input  logic          id_alu_src,
    input  logic          id_reg_write,
    input  logic          exmem_reg_write,
    input  logic [RW-1:0] exmem_rd,
    input  logic [W-1:0]  exmem_val,
    input  logic          memwb_reg_write,
    input  logic [RW-1:0] memwb_rd,
    input  logic [W-1:0]  memwb_val,
    output logic [W-1:0]  ula_a,
    output logic [W-1:0]  ula_b,
    output logic [3:0]    ula_op,
    output logic [W-1:0]  store_data,
    output logic [RW-1:0] ex_rd,
    output logic          ex_reg_write,
    output logic          ex_valid
);

    logic          valid_q;
    logic          reg_write_q;
    logic          alu_src_q;
    logic [RW-1:0] rd_q;
    logic [RW-1:0] rs_q;
    logic [RW-1:0] rt_q;
    logic [W-1:0]  rs_val_q;
    logic [W-1:0]  rt_val_q;
    logic [W-1:0]  imm_q;
    logic [3:0]    op_q;

    logic [3:0]    op_dec;
    logic [W-1:0]  imm_ext;
    logic [W-1:0]  fwd_rs;
    logic [W-1:0]  fwd_rt;

    always_comb begin
        op_dec = 4'b0010;
        unique case (id_alu_op)
            2'b00: op_dec = 4'b0010;
            2'b01: op_dec = 4'b0110;
            2'b10: begin
                case (id_funct)
                    6'b100000: op_dec = 4'b0010;
                    6'b100010: op_dec = 4'b0110;
                    6'b100100: op_dec = 4'b0000;
                    6'b100101: op_dec = 4'b0001;
                    6'b100110: op_dec = 4'b0011;
                    6'b100111: op_dec = 4'b1100;
                    6'b101010: op_dec = 4'b0111;
                    default:   op_dec = 4'b1111;
                endcase
            end
            2'b11: begin
                unique case (id_imm_op)
                    2'b00: op_dec = 4'b0000;
                    2'b01: op_dec = 4'b0001;
                    2'b10: op_dec = 4'b0011;
                    2'b11: op_dec = 4'b0111;
                endcase
            end
        endcase
    end

    // Logical immediates are unsigned; slt and arithmetic use the signed form.
    always_comb begin
        if (id_alu_op == 2'b11 && id_imm_op != 2'b11) begin
            imm_ext = {{(W-16){1'b0}}, id_imm};
        end else begin
            imm_ext = {{(W-16){id_imm[15]}}, id_imm};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            alu_src_q   <= 1'b0;
            rd_q        <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            rs_val_q    <= '0;
            rt_val_q    <= '0;
            imm_q       <= '0;
            op_q        <= 4'b0000;
        end else if (flush) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            alu_src_q   <= 1'b0;
            rd_q        <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            rs_val_q    <= '0;
            rt_val_q    <= '0;
            imm_q       <= '0;
            op_q        <= 4'b0010;
        end else if (!stall) begin
            valid_q     <= id_valid;
            reg_write_q <= id_reg_write & id_valid;
            alu_src_q   <= id_alu_src;
            rd_q        <= id_rd;
            rs_q        <= id_rs;
            rt_q        <= id_rt;
            rs_val_q    <= id_rs_val;
            rt_val_q    <= id_rt_val;
            imm_q       <= imm_ext;
            op_q        <= op_dec;
        end
    end

`ifdef ID_EX_ULA_FWD_EN
    // EX/MEM is the younger result, so it is applied last and wins.
    always_comb begin
        fwd_rs = rs_val_q;
        if (memwb_reg_write && memwb_rd != '0 && memwb_rd == rs_q) fwd_rs = memwb_val;
        if (exmem_reg_write && exmem_rd != '0 && exmem_rd == rs_q) fwd_rs = exmem_val;
        fwd_rt = rt_val_q;
        if (memwb_reg_write && memwb_rd != '0 && memwb_rd == rt_q) fwd_rt = memwb_val;
        if (exmem_reg_write && exmem_rd != '0 && exmem_rd == rt_q) fwd_rt = exmem_val;
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{exmem_reg_write, exmem_rd, exmem_val,
                          memwb_reg_write, memwb_rd, memwb_val, rs_q, rt_q};
    assign fwd_rs = rs_val_q;
    assign fwd_rt = rt_val_q;
`endif

    assign ula_a        = fwd_rs;
    assign store_data   = fwd_rt;
    assign ula_b        = alu_src_q ? imm_q : fwd_rt;
    assign ula_op       = op_q;
    assign ex_rd        = rd_q;
    assign ex_reg_write = reg_write_q;
    assign ex_valid     = valid_q;

endmodule

// File: tb/tb_id_ex_ula.sv
// Directed bench for id_ex_ula: instruction-record model checked every cycle plus literal pins.
module tb_id_ex_ula;

    logic        clock = 1'b0;
    logic        reset, stall, flush;
    logic        id_valid;
    logic [31:0] id_rs_val, id_rt_val;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [15:0] id_imm;
    logic [1:0]  id_alu_op;
    logic [5:0]  id_funct;
    logic [1:0]  id_imm_op;
    logic        id_alu_src, id_reg_write;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_val, memwb_val;
    logic [31:0] ula_a, ula_b, store_data;
    logic [3:0]  ula_op;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_valid;

    int errors = 0;
    int checks = 0;
    bit checking = 1'b0;

`ifdef ID_EX_ULA_FWD_EN
    localparam bit Fwd = 1'b1;
`else
    localparam bit Fwd = 1'b0;
`endif

    always #5 clock = ~clock;

    id_ex_ula dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_rs_val(id_rs_val), .id_rt_val(id_rt_val),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_imm(id_imm),
        .id_alu_op(id_alu_op), .id_funct(id_funct), .id_imm_op(id_imm_op),
        .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_val(exmem_val),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_val(memwb_val),
        .ula_a(ula_a), .ula_b(ula_b), .ula_op(ula_op), .store_data(store_data),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_valid(ex_valid)
    );

    // The instruction currently held in EX, as the model sees it.
    typedef struct packed {
        logic        valid;
        logic        wr;
        logic        use_imm;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] imm;
        logic [3:0]  op;
    } instr_t;

    instr_t m;

    function automatic logic [3:0] model_op(input logic [1:0] aop, input logic [5:0] f,
                                            input logic [1:0] iop);
        logic [3:0] logic_ops [4];
        logic_ops = '{4'b0000, 4'b0001, 4'b0011, 4'b0111};
        if (aop == 2'd0) return 4'b0010;
        if (aop == 2'd1) return 4'b0110;
        if (aop == 2'd3) return logic_ops[iop];
        if (f == 6'd32) return 4'b0010;
        if (f == 6'd34) return 4'b0110;
        if (f == 6'd36) return 4'b0000;
        if (f == 6'd37) return 4'b0001;
        if (f == 6'd38) return 4'b0011;
        if (f == 6'd39) return 4'b1100;
        if (f == 6'd42) return 4'b0111;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] model_imm(input logic [1:0] aop, input logic [1:0] iop,
                                              input logic [15:0] imm);
        int signed s;
        if (aop == 2'd3 && iop != 2'd3) return 32'(imm);
        s = int'(signed'(imm));
        return 32'(s);
    endfunction

    function automatic logic [31:0] model_fwd(input logic [4:0] r, input logic [31:0] v);
        if (!Fwd || r == 5'd0) return v;
        if (exmem_reg_write && exmem_rd == r) return exmem_val;
        if (memwb_reg_write && memwb_rd == r) return memwb_val;
        return v;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m <= '0;
        end else if (flush) begin
            m <= '{valid: 1'b0, wr: 1'b0, use_imm: 1'b0, rd: 5'd0, rs: 5'd0, rt: 5'd0,
                   rs_val: 32'd0, rt_val: 32'd0, imm: 32'd0, op: 4'b0010};
        end else if (!stall) begin
            m <= '{valid: id_valid, wr: id_reg_write && id_valid, use_imm: id_alu_src,
                   rd: id_rd, rs: id_rs, rt: id_rt, rs_val: id_rs_val, rt_val: id_rt_val,
                   imm: model_imm(id_alu_op, id_imm_op, id_imm),
                   op: model_op(id_alu_op, id_funct, id_imm_op)};
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (checking) begin
            logic [31:0] ea, et;
            ea = model_fwd(m.rs, m.rs_val);
            et = model_fwd(m.rt, m.rt_val);
            check("cyc_ula_a", ula_a, ea);
            check("cyc_store_data", store_data, et);
            check("cyc_ula_b", ula_b, m.use_imm ? m.imm : et);
            check("cyc_ula_op", 32'(ula_op), 32'(m.op));
            check("cyc_ex_rd", 32'(ex_rd), 32'(m.rd));
            check("cyc_ex_reg_write", 32'(ex_reg_write), 32'(m.wr));
            check("cyc_ex_valid", 32'(ex_valid), 32'(m.valid));
        end
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic set_id(input logic [1:0] aop, input logic [5:0] f, input logic [1:0] iop,
                          input logic [4:0] rs, input logic [31:0] rsv,
                          input logic [4:0] rt, input logic [31:0] rtv,
                          input logic [15:0] imm, input logic src);
        id_valid = 1'b1; id_reg_write = 1'b1; id_rd = 5'd9;
        id_alu_op = aop; id_funct = f; id_imm_op = iop;
        id_rs = rs; id_rs_val = rsv; id_rt = rt; id_rt_val = rtv;
        id_imm = imm; id_alu_src = src;
    endtask

    logic [5:0] funct_tab [7];
    logic [3:0] op_tab [7];

    initial begin
        funct_tab = '{6'b100000, 6'b100100, 6'b100101, 6'b100110, 6'b100111, 6'b101010,
                      6'b000000};
        op_tab    = '{4'b0010, 4'b0000, 4'b0001, 4'b0011, 4'b1100, 4'b0111, 4'b1111};
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        exmem_reg_write = 1'b0; exmem_rd = 5'd0; exmem_val = 32'd0;
        memwb_reg_write = 1'b0; memwb_rd = 5'd0; memwb_val = 32'd0;
        set_id(2'b10, 6'b100000, 2'b01, 5'd3, 32'h55, 5'd4, 32'h66, 16'h1234, 1'b1);

        // Reset with live-looking ID inputs
        step(); step();
        checking = 1'b1;
        check("rst_valid", 32'(ex_valid), 32'd0);
        check("rst_op", 32'(ula_op), 32'd0);
        check("rst_a", ula_a, 32'd0);
        check("rst_b", ula_b, 32'd0);
        reset = 1'b0;

        // R-type sub, then unknown funct
        set_id(2'b10, 6'b100010, 2'b00, 5'd1, 32'd7, 5'd2, 32'd3, 16'h0000, 1'b0);
        step();
        check("sub_op", 32'(ula_op), 32'b0110);
        check("sub_a", ula_a, 32'd7);
        check("sub_b", ula_b, 32'd3);
        id_funct = 6'b101111;
        step();
        check("bad_funct_op", 32'(ula_op), 32'b1111);

        for (int i = 0; i < 7; i++) begin
            id_funct = funct_tab[i];
            step();
            check("funct_table_op", 32'(ula_op), 32'(op_tab[i]));
        end

        // Immediate extension
        set_id(2'b11, 6'b000000, 2'b01, 5'd1, 32'd7, 5'd2, 32'd3, 16'hFFFF, 1'b1);
        step();
        check("ori_b", ula_b, 32'h0000FFFF);
        check("ori_op", 32'(ula_op), 32'b0001);
        id_imm_op = 2'b11;
        step();
        check("slti_b", ula_b, 32'hFFFFFFFF);
        check("slti_op", 32'(ula_op), 32'b0111);
        id_alu_op = 2'b00;
        step();
        check("addi_b", ula_b, 32'hFFFFFFFF);
        check("addi_op", 32'(ula_op), 32'b0010);

        // Forwarding on rs=5
        set_id(2'b00, 6'b000000, 2'b00, 5'd5, 32'd1, 5'd6, 32'd9, 16'h0000, 1'b0);
        step();
        exmem_reg_write = 1'b1; exmem_rd = 5'd5; exmem_val = 32'd100;
        memwb_reg_write = 1'b1; memwb_rd = 5'd5; memwb_val = 32'd200;
        #1;
        check("fwd_exmem_a", ula_a, Fwd ? 32'd100 : 32'd1);
        exmem_reg_write = 1'b0;
        #1;
        check("fwd_memwb_a", ula_a, Fwd ? 32'd200 : 32'd1);
        memwb_rd = 5'd6;
        #1;
        check("fwd_rt_store", store_data, Fwd ? 32'd200 : 32'd9);
        id_rs = 5'd0;
        step();
        exmem_reg_write = 1'b1; exmem_rd = 5'd0; memwb_rd = 5'd0;
        #1;
        check("fwd_r0_a", ula_a, 32'd1);
        step();
        exmem_reg_write = 1'b0; memwb_reg_write = 1'b0;

        // Stall holds, flush beats stall
        set_id(2'b00, 6'b000000, 2'b00, 5'd1, 32'd4, 5'd2, 32'd6, 16'h0000, 1'b0);
        step();
        stall = 1'b1;
        set_id(2'b10, 6'b100111, 2'b00, 5'd7, 32'd11, 5'd8, 32'd22, 16'h00FF, 1'b1);
        step(); step(); step();
        check("stall_a", ula_a, 32'd4);
        check("stall_b", ula_b, 32'd6);
        check("stall_op", 32'(ula_op), 32'b0010);
        flush = 1'b1;
        step();
        check("flush_valid", 32'(ex_valid), 32'd0);
        check("flush_wr", 32'(ex_reg_write), 32'd0);
        check("flush_op", 32'(ula_op), 32'b0010);
        flush = 1'b0; stall = 1'b0;

        // Reset overriding stall mid-operation
        step();
        check("live_valid", 32'(ex_valid), 32'd1);
        stall = 1'b1; reset = 1'b1;
        step();
        check("mid_rst_valid", 32'(ex_valid), 32'd0);
        check("mid_rst_wr", 32'(ex_reg_write), 32'd0);
        check("mid_rst_op", 32'(ula_op), 32'd0);
        check("mid_rst_a", ula_a, 32'd0);
        check("mid_rst_b", ula_b, 32'd0);
        check("mid_rst_rd", 32'(ex_rd), 32'd0);
        reset = 1'b0; stall = 1'b0;
        step();
        check("resume_valid", 32'(ex_valid), 32'd1);
        check("resume_a", ula_a, 32'd11);
        check("resume_op", 32'(ula_op), 32'b1100);
        id_valid = 1'b0;
        step();
        check("invalid_wr", 32'(ex_reg_write), 32'd0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_ula.md
Name: id_ex_ula

Overview:
- ID/EX pipeline stage directly upstream of the 32-bit ULA.
- Captures decoded operands and control on each clock, and translates ALUOp/funct into the ULA's 4-bit OP code.
- Resolves data hazards by forwarding from EX/MEM and MEM/WB, then drives ULA inputs A, B and OP.
- Supports pipeline stall (hold) and flush (bubble).

Parameters:
- W, 32, datapath width.
- RW, 5, register-number width.

Ports:
- clock  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold all stage registers.
- flush  in  1  load a bubble.
- id_valid  in  1  decode stage presents an instruction.
- id_rs_val  in  W  register-file read data for rs.
- id_rt_val  in  W  register-file read data for rt.
- id_rs  in  RW  rs register number.
- id_rt  in  RW  rt register number.
- id_rd  in  RW  destination register number.
- id_imm  in  16  immediate field.
- id_alu_op  in  2  00 add, 01 sub, 10 R-type (use funct), 11 immediate-logical (use imm_op).
- id_funct  in  6  R-type function field.
- id_imm_op  in  2  00 and, 01 or, 10 xor, 11 slt.
- id_alu_src  in  1  1 = B from immediate.
- id_reg_write  in  1  instruction writes the register file.
- exmem_reg_write  in  1  EX/MEM forwarding source write enable.
- exmem_rd  in  RW  EX/MEM destination register.
- exmem_val  in  W  EX/MEM forwarded value.
- memwb_reg_write  in  1  MEM/WB forwarding source write enable.
- memwb_rd  in  RW  MEM/WB destination register.
- memwb_val  in  W  MEM/WB forwarded value.
- ula_a  out  W  operand A to the ULA.
- ula_b  out  W  operand B to the ULA.
- ula_op  out  4  OP code to the ULA.
- store_data  out  W  forwarded rt value, for stores.
- ex_rd  out  RW  registered destination register.
- ex_reg_write  out  1  registered write enable.
- ex_valid  out  1  stage holds a live instruction.

Behaviour:
- Latency: 1 cycle, ID inputs to registered EX state. Forwarding muxes on ula_a, ula_b and store_data are combinational from registered state plus the exmem_/memwb_ inputs.
- Register update priority, top wins:
  - reset: all registers zero, including ex_valid and ex_reg_write. ula_op is then 4'b0000 and ula_a = ula_b = 0. Reset overrides stall and flush.
  - flush: bubble. ex_valid=0, ex_reg_write=0, ex_rd=0, ula_op=4'b0010, operands and immediate zero. Flush overrides stall.
  - stall: every register holds its value. Forwarding stays live, because sources may change.
  - otherwise: capture the ID inputs. ex_valid=id_valid; ex_reg_write=id_reg_write & id_valid.
- OP decode, registered at capture:
  - alu_op 00 → 0010; 01 → 0110.
  - alu_op 10, by funct: 100000 → 0010; 100010 → 0110; 100100 → 0000; 100101 → 0001; 100110 → 0011; 100111 → 1100; 101010 → 0111; any other → 1111 (the ULA then yields 0).
  - alu_op 11, by imm_op: 00 → 0000; 01 → 0001; 10 → 0011; 11 → 0111.
- Immediate extension, registered:
  - Zero-extend when alu_op=11 and imm_op≠11.
  - Sign-extend otherwise.
- Forwarding, per source operand (rs, rt):
  - EX/MEM hit when exmem_reg_write=1, exmem_rd≠0 and exmem_rd equals the operand's register number.
  - MEM/WB hit under the same three conditions on memwb_reg_write / memwb_rd.
  - EX/MEM has priority over MEM/WB. No hit → registered value.
  - Register 0 never forwards.
- ula_a = forwarded rs.
- store_data = forwarded rt.
- ula_b = extended immediate when alu_src=1, else forwarded rt.
- The ULA has no valid input, so a bubble (ex_valid=0) still drives operands; downstream stages qualify results with ex_valid.

Optional Feature:
- Macro ID_EX_ULA_FWD_EN.
- Defined: forwarding as specified above.
- Undefined: the exmem_/memwb_ inputs are ignored. ula_a, ula_b and store_data come straight from registered state, and hazards must be resolved by stalling.
- Port list is identical in both builds.

Test Plan:
1. Reset held 2 cycles while id inputs are non-zero → ex_valid=0, ula_op=0000, ula_a=0, ula_b=0.
2. R-type: funct=100010, rs_val=7, rt_val=3, alu_src=0 → next cycle ula_op=0110, ula_a=7, ula_b=3. Then funct=101111 → ula_op=1111.
3. Immediate extension:
   - alu_op=11, imm_op=01, imm=16'hFFFF → ula_b=32'h0000FFFF, ula_op=0001.
   - alu_op=00, imm=16'hFFFF, alu_src=1 → ula_b=32'hFFFFFFFF, ula_op=0010.
4. Forwarding, with rs=5 registered as 1:
   - exmem (rw=1, rd=5, val=100) and memwb (rw=1, rd=5, val=200) → ula_a=100.
   - Drop exmem_reg_write → ula_a=200.
   - Same hits with rs=0 → ula_a=registered value.
5. Stall and flush:
   - Capture add 4+6, then stall=1 for 3 cycles with new id inputs → outputs unchanged (ula_a=4, ula_b=6).
   - stall=1 and flush=1 together → ex_valid=0, ex_reg_write=0, ula_op=0010.
6. Reset mid-operation: ex_valid=1 and stall=1, assert reset 1 cycle → all outputs zero, then normal capture resumes the next cycle.
